// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : cpu_pkg
//  Purpose : Shared definitions for the single-cycle CPU instruction-memory
//            responder: loader/fetch state encoding, the NOP word and a
//            helper that left-aligns a partially assembled word.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package cpu_pkg;

    // Loader / fetch state encoding
    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        FLUSH = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0000;

    // The assembly register holds the most recent bytes right-aligned.
    // A partial word must be stored with its first byte in bits [31:24],
    // so shift it up and zero-fill the missing low bytes.
    function automatic logic [31:0] left_align(input logic [31:0] assembled,
                                               input logic [1:0]  nbytes);
        logic [31:0] word;
        case (nbytes)
            2'd1:    word = {assembled[7:0],  24'h00_0000};
            2'd2:    word = {assembled[15:0], 16'h0000};
            2'd3:    word = {assembled[23:0], 8'h00};
            default: word = assembled;
        endcase
        return word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_mem_responder_ram.sv
`default_nettype none
// ============================================================================
//  Module  : instr_ram
//  Purpose : Word-wide instruction storage with a synchronous write port
//            and an asynchronous (combinational) read port.
//  Ports   : clk            write clock
//            we             write enable
//            waddr [AW-1:0] write word address
//            wdata [31:0]   write data
//            raddr [AW-1:0] read word address
//            rdata [31:0]   read data (combinational)
//  Rev     : 1.0  initial release
// ============================================================================
module instr_ram #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [2**AW];

    // No reset: reads are gated by the loaded word count, so stale
    // contents are never observed.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/instr_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module  : instr_mem_responder
//  Purpose : Instruction memory for the fetch stage. After reset it accepts a
//            big-endian byte stream, packs it into 32-bit words written from
//            word 0 upward, then raises Run and serves combinational reads.
//  Ports   : Clk                 system clock
//            Reset               asynchronous active-high reset (to LOAD)
//            LoadValid           LoadByte valid this cycle
//            LoadByte [7:0]      program byte, MSB of each word first
//            LoadLast            final program byte (qualified by LoadValid)
//            LoadReady           byte accepted when LoadValid & LoadReady
//            Run                 fetch enable, high only in RUN
//            Addr [31:0]         fetch byte address
//            Instruction [31:0]  word at Addr, or NOP when not servable
//            AddrError           in RUN: Addr misaligned or beyond program
//            WordCount [AW:0]    words written during load
//  Rev     : 1.0  initial release
// ============================================================================
module instr_mem_responder #(
    parameter int AW = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          LoadValid,
    input  logic [7:0]    LoadByte,
    input  logic          LoadLast,
    output logic          LoadReady,
    output logic          Run,
    input  logic [31:0]   Addr,
    output logic [31:0]   Instruction,
    output logic          AddrError,
    output logic [AW:0]   WordCount
);
    import cpu_pkg::*;

    localparam logic [AW:0] LAST_WORD = (AW+1)'(2**AW - 1);
    localparam logic [AW:0] WC_ONE    = (AW+1)'(1);

    state_t        state;
    logic [31:0]   assembly;
    logic [1:0]    byte_cnt;
    logic [AW:0]   word_count;
    logic          load_ready;
    logic          run;

    logic          accept;
    logic          word_done;
    logic [31:0]   next_word;
    logic          we;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic [AW-1:0] rd_index;
    logic          hit;

    assign accept    = (state == LOAD) && LoadValid;
    assign next_word = {assembly[23:0], LoadByte};
    assign word_done = accept && (byte_cnt == 2'd3);

    assign we    = word_done || (state == FLUSH);
    assign wdata = (state == FLUSH) ? left_align(assembly, byte_cnt) : next_word;

    instr_ram #(
        .AW (AW)
    ) u_ram (
        .clk   (Clk),
        .we    (we),
        .waddr (word_count[AW-1:0]),
        .wdata (wdata),
        .raddr (rd_index),
        .rdata (rdata)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= LOAD;
            assembly   <= 32'h0;
            byte_cnt   <= 2'd0;
            word_count <= '0;
            load_ready <= 1'b1;
            run        <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        assembly <= next_word;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            word_count <= word_count + WC_ONE;
                            // Filling the last location ends the load even
                            // without LoadLast; the stream beyond is dropped.
                            if (LoadLast || (word_count == LAST_WORD)) begin
                                state      <= RUN;
                                load_ready <= 1'b0;
                                run        <= 1'b1;
                            end
                        end else if (LoadLast) begin
                            state      <= FLUSH;
                            load_ready <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    word_count <= word_count + WC_ONE;
                    byte_cnt   <= 2'd0;
                    assembly   <= 32'h0;
                    state      <= RUN;
                    run        <= 1'b1;
                end
                RUN: begin
                    // Terminal until Reset; load traffic is ignored.
                end
                default: begin
                    state      <= LOAD;
                    load_ready <= 1'b1;
                    run        <= 1'b0;
                end
            endcase
        end
    end

    // Read path: serve only aligned addresses whose upper bits are clear
    // and whose word index lies inside the loaded program.
    assign rd_index = Addr[AW+1:2];
    assign hit = (state == RUN)
              && (Addr[1:0] == 2'b00)
              && ((Addr >> (AW + 2)) == 32'h0)
              && ({1'b0, rd_index} < word_count);

    assign Instruction = hit ? rdata : NOP;
    assign AddrError   = (state == RUN) && !hit;
    assign LoadReady   = load_ready;
    assign Run         = run;
    assign WordCount   = word_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_responder.sv
`timescale 1ns/1ps
module tb_instr_mem_responder;

    localparam int AW  = 8;
    localparam int AWS = 2;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Main instance (AW = 8)
    logic          Reset = 1'b1;
    logic          LoadValid = 1'b0;
    logic [7:0]    LoadByte = 8'h00;
    logic          LoadLast = 1'b0;
    logic          LoadReady;
    logic          Run;
    logic [31:0]   Addr = 32'h0;
    logic [31:0]   Instruction;
    logic          AddrError;
    logic [AW:0]   WordCount;

    // Small instance (AW = 2) for the memory-full case
    logic          sm_Reset = 1'b1;
    logic          sm_LoadValid = 1'b0;
    logic [7:0]    sm_LoadByte = 8'h00;
    logic          sm_LoadLast = 1'b0;
    logic          sm_LoadReady;
    logic          sm_Run;
    logic [31:0]   sm_Addr = 32'h0;
    logic [31:0]   sm_Instruction;
    logic          sm_AddrError;
    logic [AWS:0]  sm_WordCount;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] prog[$];
    logic [7:0] sprog[$];

    instr_mem_responder #(.AW(AW)) dut (
        .Clk(Clk), .Reset(Reset), .LoadValid(LoadValid), .LoadByte(LoadByte),
        .LoadLast(LoadLast), .LoadReady(LoadReady), .Run(Run), .Addr(Addr),
        .Instruction(Instruction), .AddrError(AddrError), .WordCount(WordCount)
    );

    instr_mem_responder #(.AW(AWS)) dut_small (
        .Clk(Clk), .Reset(sm_Reset), .LoadValid(sm_LoadValid), .LoadByte(sm_LoadByte),
        .LoadLast(sm_LoadLast), .LoadReady(sm_LoadReady), .Run(sm_Run), .Addr(sm_Addr),
        .Instruction(sm_Instruction), .AddrError(sm_AddrError), .WordCount(sm_WordCount)
    );

    // ---------------- reference model (byte-stream view) ----------------
    function automatic int exp_wc(input int nbytes, input int depth);
        int w;
        w = (nbytes + 3) / 4;
        return (w > depth) ? depth : w;
    endfunction

    function automatic logic [31:0] exp_word(input logic [7:0] q[$], input int idx);
        logic [31:0] w;
        w = 32'h0;
        for (int k = 0; k < 4; k++) begin
            int p;
            p = idx * 4 + k;
            w = {w[23:0], (p < q.size()) ? q[p] : 8'h00};
        end
        return w;
    endfunction

    function automatic logic exp_err(input logic [31:0] a, input int wc);
        return (a % 4 != 0) || ((a / 4) >= 32'(wc));
    endfunction

    function automatic logic [31:0] exp_instr(input logic [7:0] q[$], input logic [31:0] a, input int wc);
        if (exp_err(a, wc)) return 32'h0;
        return exp_word(q, int'(a / 4));
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive_byte(input logic [7:0] b, input logic last);
        @(negedge Clk);
        LoadValid = 1'b1;
        LoadByte  = b;
        LoadLast  = last;
        @(posedge Clk);
        #1;
        LoadValid = 1'b0;
        LoadLast  = 1'b0;
    endtask

    task automatic do_reset;
        @(negedge Clk);
        Reset = 1'b1;
        sm_Reset = 1'b1;
        LoadValid = 1'b0;
        LoadLast = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        sm_Reset = 1'b0;
        prog.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        do_reset();
        Addr = 32'h0;
        #1;
        vectors++; if (LoadReady !== 1'b1) begin miscompares++; $display("FAIL reset_loadready: got %b want 1", LoadReady); end
        vectors++; if (Run !== 1'b0) begin miscompares++; $display("FAIL reset_run: got %b want 0", Run); end
        vectors++; if (WordCount !== '0) begin miscompares++; $display("FAIL reset_wordcount: got %0d want 0", WordCount); end
        vectors++; if (Instruction !== 32'h0) begin miscompares++; $display("FAIL reset_instr: got %h want 0", Instruction); end
        vectors++; if (AddrError !== 1'b0) begin miscompares++; $display("FAIL reset_addrerror: got %b want 0", AddrError); end
        vectors++; if (sm_LoadReady !== 1'b1 || sm_WordCount !== '0) begin
            miscompares++; $display("FAIL reset_small: got ready=%b wc=%0d want 1/0", sm_LoadReady, sm_WordCount);
        end
    endtask

    task automatic test_full_words;
        logic [7:0] b[8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            prog.push_back(b[i]);
            drive_byte(b[i], i == 7);
            if (i == 3) begin
                vectors++; if (WordCount !== 9'd1 || Run !== 1'b0) begin
                    miscompares++; $display("FAIL first_word: got wc=%0d run=%b want 1/0", WordCount, Run);
                end
            end
        end
        vectors++; if (Run !== 1'b1) begin miscompares++; $display("FAIL run_same_cycle: got %b want 1", Run); end
        vectors++; if (WordCount !== 9'd2) begin miscompares++; $display("FAIL full_wc: got %0d want 2", WordCount); end
        vectors++; if (LoadReady !== 1'b0) begin miscompares++; $display("FAIL full_ready: got %b want 0", LoadReady); end
        Addr = 32'h0; #1;
        vectors++; if (Instruction !== 32'h2008_0005) begin miscompares++; $display("FAIL full_word0: got %h want 20080005", Instruction); end
        vectors++; if (AddrError !== 1'b0) begin miscompares++; $display("FAIL full_err0: got %b want 0", AddrError); end
        Addr = 32'h4; #1;
        vectors++; if (Instruction !== 32'h2009_0007) begin miscompares++; $display("FAIL full_word1: got %h want 20090007", Instruction); end
    endtask

    task automatic test_partial;
        logic [7:0] b[6] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            prog.push_back(b[i]);
            drive_byte(b[i], i == 5);
        end
        vectors++; if (Run !== 1'b0 || LoadReady !== 1'b0 || WordCount !== 9'd1) begin
            miscompares++; $display("FAIL flush_cycle: got run=%b ready=%b wc=%0d want 0/0/1", Run, LoadReady, WordCount);
        end
        @(posedge Clk); #1;
        vectors++; if (Run !== 1'b1 || WordCount !== 9'd2) begin
            miscompares++; $display("FAIL after_flush: got run=%b wc=%0d want 1/2", Run, WordCount);
        end
        Addr = 32'h0; #1;
        vectors++; if (Instruction !== 32'hAABB_CCDD) begin miscompares++; $display("FAIL partial_word0: got %h want aabbccdd", Instruction); end
        Addr = 32'h4; #1;
        vectors++; if (Instruction !== 32'h1122_0000) begin miscompares++; $display("FAIL partial_word1: got %h want 11220000", Instruction); end
    endtask

    task automatic test_addr_error;
        logic [31:0] addrs[3] = '{32'h2, 32'h8, 32'h400};
        foreach (addrs[i]) begin
            Addr = addrs[i]; #1;
            vectors++; if (Instruction !== 32'h0 || AddrError !== 1'b1) begin
                miscompares++; $display("FAIL addr_error @%h: got instr=%h err=%b want 0/1", Addr, Instruction, AddrError);
            end
        end
    endtask

    task automatic test_mem_full;
        sprog.delete();
        for (int i = 0; i < 20; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            @(negedge Clk);
            vectors++; if (sm_LoadReady !== (i < 16)) begin
                miscompares++; $display("FAIL full_ready byte %0d: got %b want %b", i + 1, sm_LoadReady, (i < 16));
            end
            if (i < 16) sprog.push_back(b);
            sm_LoadValid = 1'b1;
            sm_LoadByte  = b;
            @(posedge Clk); #1;
            sm_LoadValid = 1'b0;
        end
        vectors++; if (sm_WordCount !== 3'd4 || sm_Run !== 1'b1) begin
            miscompares++; $display("FAIL mem_full: got wc=%0d run=%b want 4/1", sm_WordCount, sm_Run);
        end
        for (int w = 0; w < 4; w++) begin
            sm_Addr = 32'(w * 4); #1;
            vectors++; if (sm_Instruction !== exp_word(sprog, w)) begin
                miscompares++; $display("FAIL mem_full_word%0d: got %h want %h", w, sm_Instruction, exp_word(sprog, w));
            end
        end
        sm_Addr = 32'h10; #1;
        vectors++; if (sm_Instruction !== 32'h0 || sm_AddrError !== 1'b1) begin
            miscompares++; $display("FAIL mem_full_oob: got instr=%h err=%b want 0/1", sm_Instruction, sm_AddrError);
        end
    endtask

    task automatic test_reset_midload;
        do_reset();
        for (int i = 0; i < 3; i++) drive_byte(8'($urandom), 1'b0);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        vectors++; if (WordCount !== '0 || Run !== 1'b0 || LoadReady !== 1'b1) begin
            miscompares++; $display("FAIL midload_reset: got wc=%0d run=%b ready=%b want 0/0/1", WordCount, Run, LoadReady);
        end
        prog.delete();
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            prog.push_back(b);
            drive_byte(b, i == 3);
        end
        Addr = 32'h0; #1;
        vectors++; if (WordCount !== 9'd1 || Instruction !== exp_word(prog, 0)) begin
            miscompares++; $display("FAIL reload: got wc=%0d instr=%h want 1/%h", WordCount, Instruction, exp_word(prog, 0));
        end
    endtask

    task automatic test_run_ignore;
        for (int i = 0; i < 8; i++) drive_byte(8'($urandom), i == 7);
        Addr = 32'h0; #1;
        vectors++; if (WordCount !== 9'd1 || Run !== 1'b1 || Instruction !== exp_word(prog, 0)) begin
            miscompares++; $display("FAIL run_ignore: got wc=%0d run=%b instr=%h want 1/1/%h", WordCount, Run, Instruction, exp_word(prog, 0));
        end
    endtask

    task automatic test_random_programs;
        for (int t = 0; t < 6; t++) begin
            int n;
            int wc;
            do_reset();
            n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) begin
                logic [7:0] b;
                b = 8'($urandom);
                prog.push_back(b);
                drive_byte(b, i == n - 1);
            end
            if (n % 4 != 0) begin
                vectors++; if (Run !== 1'b0) begin miscompares++; $display("FAIL rand_flush n=%0d: got run=%b want 0", n, Run); end
                @(posedge Clk); #1;
            end
            wc = exp_wc(n, 2**AW);
            vectors++; if (Run !== 1'b1 || WordCount !== (AW+1)'(wc)) begin
                miscompares++; $display("FAIL rand_done n=%0d: got run=%b wc=%0d want 1/%0d", n, Run, WordCount, wc);
            end
            for (int k = 0; k < 12; k++) begin
                logic [31:0] a;
                case ($urandom_range(0, 3))
                    0, 1: a = 32'($urandom_range(0, wc + 2) * 4);
                    2:    a = 32'($urandom_range(0, 63));
                    default: a = $urandom;
                endcase
                Addr = a; #1;
                vectors++; if (Instruction !== exp_instr(prog, a, wc) || AddrError !== exp_err(a, wc)) begin
                    miscompares++; $display("FAIL rand_read @%h: got instr=%h err=%b want %h/%b", a, Instruction, AddrError, exp_instr(prog, a, wc), exp_err(a, wc));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_words();
        test_partial();
        test_addr_error();
        test_mem_full();
        test_reset_midload();
        test_run_ignore();
        test_random_programs();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
